// File: rtl/data_bus_if_pkg.sv
// Shared types and constants for the CPU-to-bus data interface.
package data_bus_if_pkg;

   localparam int unsigned ADDR_W  = 32;
   localparam int unsigned DATA_W  = 32;
   localparam int unsigned SEL_W   = 4;
   localparam int unsigned STALL_W = 6;

   localparam logic [DATA_W-1:0] ZERO_WORD = '0;

   // Bus-side FSM states; 2-bit encodings are shared with the rest of the core.
   typedef enum logic [1:0] {
      ST_IDLE       = 2'b00,
      ST_BUSY       = 2'b01,
      ST_WAIT_STALL = 2'b11
   } bus_state_e;

   // Registered bus request payload (address, store data, direction, lanes).
   typedef struct packed {
      logic [ADDR_W-1:0] adr;
      logic [DATA_W-1:0] dat;
      logic              we;
      logic [SEL_W-1:0]  sel;
   } wb_req_t;

endpackage

// File: rtl/data_bus_if.sv
// Data-side bus master: turns memory-stage loads/stores into single bus
// cycles, stalls the pipeline while the slave is busy and buffers load data
// while the rest of the pipeline is still stalled.
module data_bus_if
   import data_bus_if_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,

   input  logic                cpu_ce_i,
   input  logic                cpu_we_i,
   input  logic [ADDR_W-1:0]   cpu_addr_i,
   input  logic [SEL_W-1:0]    cpu_sel_i,
   input  logic [DATA_W-1:0]   cpu_data_i,

   input  logic [STALL_W-1:0]  stall_i,
   input  logic                flush_i,

   output logic [DATA_W-1:0]   cpu_data_o,
   output logic                stallreq_o,

   output logic [ADDR_W-1:0]   wb_adr_o,
   output logic [DATA_W-1:0]   wb_dat_o,
   input  logic [DATA_W-1:0]   wb_dat_i,
   output logic                wb_we_o,
   output logic [SEL_W-1:0]    wb_sel_o,
   output logic                wb_stb_o,
   output logic                wb_cyc_o,
   input  logic                wb_ack_i
);

   bus_state_e        state;
   wb_req_t           req_q;
   logic              bus_act_q;
   logic [DATA_W-1:0] rd_buf;

   // Bus-side outputs come straight from the request registers.
   assign wb_adr_o = req_q.adr;
   assign wb_dat_o = req_q.dat;
   assign wb_we_o  = req_q.we;
   assign wb_sel_o = req_q.sel;
   assign wb_stb_o = bus_act_q;
   assign wb_cyc_o = bus_act_q;

   // State, bus request registers and load-data buffer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         req_q     <= '0;
         bus_act_q <= 1'b0;
         rd_buf    <= ZERO_WORD;
      end else begin
         case (state)
            ST_IDLE: begin
               if (cpu_ce_i && !flush_i) begin
                  req_q.adr <= cpu_addr_i;
                  req_q.dat <= cpu_data_i;
                  req_q.we  <= cpu_we_i;
                  req_q.sel <= cpu_sel_i;
                  bus_act_q <= 1'b1;
                  state     <= ST_BUSY;
               end else begin
                  req_q     <= '0;
                  bus_act_q <= 1'b0;
               end
            end
            ST_BUSY: begin
               if (flush_i) begin
                  // Flush wins over a same-cycle ack; the access is dropped.
                  req_q     <= '0;
                  bus_act_q <= 1'b0;
                  rd_buf    <= ZERO_WORD;
                  state     <= ST_IDLE;
               end else if (wb_ack_i) begin
                  req_q     <= '0;
                  bus_act_q <= 1'b0;
                  rd_buf    <= req_q.we ? ZERO_WORD : wb_dat_i;
                  state     <= (stall_i != '0) ? ST_WAIT_STALL : ST_IDLE;
               end
            end
            ST_WAIT_STALL: begin
               if (flush_i) begin
                  rd_buf <= ZERO_WORD;
                  state  <= ST_IDLE;
               end else if (stall_i == '0) begin
                  state  <= ST_IDLE;
               end
            end
            default: begin
               req_q     <= '0;
               bus_act_q <= 1'b0;
               rd_buf    <= ZERO_WORD;
               state     <= ST_IDLE;
            end
         endcase
      end
   end

   // CPU-facing load data and stall request, decoded from the current state.
   always_comb begin
      cpu_data_o = ZERO_WORD;
      stallreq_o = 1'b0;
      if (rst_n) begin
         case (state)
            ST_IDLE: begin
               stallreq_o = cpu_ce_i && !flush_i;
            end
            ST_BUSY: begin
               if (!flush_i) begin
                  if (wb_ack_i) begin
                     cpu_data_o = wb_dat_i;
                  end else begin
                     stallreq_o = 1'b1;
                  end
               end
            end
            ST_WAIT_STALL: begin
               if (!flush_i) begin
                  cpu_data_o = rd_buf;
               end
            end
            default: begin
               cpu_data_o = ZERO_WORD;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_data_bus_if.sv
// Self-checking bench for data_bus_if: a per-cycle vector table replayed
// through a scoreboard queue, plus hand-written flush and reset sequences.
module tb_data_bus_if;
   import data_bus_if_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        cpu_ce_i, cpu_we_i;
   logic [31:0] cpu_addr_i, cpu_data_i;
   logic [3:0]  cpu_sel_i;
   logic [5:0]  stall_i;
   logic        flush_i;
   logic [31:0] cpu_data_o;
   logic        stallreq_o;
   logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
   logic        wb_we_o, wb_stb_o, wb_cyc_o, wb_ack_i;
   logic [3:0]  wb_sel_o;

   data_bus_if dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cpu_ce_i   (cpu_ce_i),
      .cpu_we_i   (cpu_we_i),
      .cpu_addr_i (cpu_addr_i),
      .cpu_sel_i  (cpu_sel_i),
      .cpu_data_i (cpu_data_i),
      .stall_i    (stall_i),
      .flush_i    (flush_i),
      .cpu_data_o (cpu_data_o),
      .stallreq_o (stallreq_o),
      .wb_adr_o   (wb_adr_o),
      .wb_dat_o   (wb_dat_o),
      .wb_dat_i   (wb_dat_i),
      .wb_we_o    (wb_we_o),
      .wb_sel_o   (wb_sel_o),
      .wb_stb_o   (wb_stb_o),
      .wb_cyc_o   (wb_cyc_o),
      .wb_ack_i   (wb_ack_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic        ce;
      logic        we;
      logic [31:0] addr;
      logic [3:0]  sel;
      logic [31:0] data;
      logic [5:0]  stall;
      logic        flush;
      logic        ack;
      logic [31:0] dati;
   } in_t;

   typedef struct packed {
      in_t         i;
      logic        e_stallreq;
      logic [31:0] e_cdata;
      logic        chk_cdata;
      logic        e_busy;
      wb_req_t     e_wb;
   } vec_t;

   vec_t tbl[$];
   vec_t exp_q[$];
   int   n_vec  = 0;
   int   n_miss = 0;

   // Bounded run time in case the bench itself stalls.
   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, summary not yet printed");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   function automatic in_t mk_req(input logic we, input logic [31:0] addr,
                                  input logic [3:0] sel, input logic [31:0] data);
      in_t r;
      r      = '0;
      r.ce   = 1'b1;
      r.we   = we;
      r.addr = addr;
      r.sel  = sel;
      r.data = data;
      return r;
   endfunction

   function automatic wb_req_t mk_wb(input logic [31:0] adr, input logic [31:0] dat,
                                     input logic we, input logic [3:0] sel);
      wb_req_t w;
      w.adr = adr;
      w.dat = dat;
      w.we  = we;
      w.sel = sel;
      return w;
   endfunction

   task automatic add(input in_t i, input logic es, input logic [31:0] ecd,
                      input logic chkd, input logic eb, input wb_req_t ew);
      vec_t v;
      v.i = i; v.e_stallreq = es; v.e_cdata = ecd;
      v.chk_cdata = chkd; v.e_busy = eb; v.e_wb = ew;
      tbl.push_back(v);
   endtask

   task automatic drive(input in_t i);
      cpu_ce_i   = i.ce;
      cpu_we_i   = i.we;
      cpu_addr_i = i.addr;
      cpu_sel_i  = i.sel;
      cpu_data_i = i.data;
      stall_i    = i.stall;
      flush_i    = i.flush;
      wb_ack_i   = i.ack;
      wb_dat_i   = i.dati;
   endtask

   // One clock cycle: drive just after the rising edge, return at the falling edge.
   task automatic cyc(input in_t i);
      @(posedge clk);
      #1 drive(i);
      @(negedge clk);
   endtask

   task automatic compare_row(input int k, input vec_t v);
      chk($sformatf("row%0d stallreq", k), 32'(stallreq_o), 32'(v.e_stallreq));
      if (v.chk_cdata) chk($sformatf("row%0d cpu_data", k), cpu_data_o, v.e_cdata);
      chk($sformatf("row%0d stb", k), 32'(wb_stb_o), 32'(v.e_busy));
      chk($sformatf("row%0d cyc", k), 32'(wb_cyc_o), 32'(v.e_busy));
      chk($sformatf("row%0d adr", k), wb_adr_o, v.e_wb.adr);
      chk($sformatf("row%0d dat", k), wb_dat_o, v.e_wb.dat);
      chk($sformatf("row%0d we", k), 32'(wb_we_o), 32'(v.e_wb.we));
      chk($sformatf("row%0d sel", k), 32'(wb_sel_o), 32'(v.e_wb.sel));
   endtask

   initial begin
      in_t     idle, rq, ri;
      wb_req_t w;
      vec_t    v;
      idle = '0;

      // ---- vector table: each row is one clock cycle ----
      add(idle, 1'b0, 32'h0, 1'b1, 1'b0, '0);
      // zero-wait read
      rq = mk_req(1'b0, 32'h0000_0010, 4'hF, 32'h0);
      w  = mk_wb(32'h0000_0010, 32'h0, 1'b0, 4'hF);
      add(rq, 1'b1, 32'h0, 1'b1, 1'b0, '0);
      ri = rq; ri.ack = 1'b1; ri.dati = 32'hDEAD_BEEF;
      add(ri, 1'b0, 32'hDEAD_BEEF, 1'b1, 1'b1, w);
      add(idle, 1'b0, 32'h0, 1'b1, 1'b0, '0);
      // write with three wait states
      rq = mk_req(1'b1, 32'h0000_0020, 4'b1000, 32'hAB00_0000);
      w  = mk_wb(32'h0000_0020, 32'hAB00_0000, 1'b1, 4'b1000);
      add(rq, 1'b1, 32'h0, 1'b1, 1'b0, '0);
      for (int k = 0; k < 3; k++) add(rq, 1'b1, 32'h0, 1'b1, 1'b1, w);
      ri = rq; ri.ack = 1'b1; ri.dati = 32'h55AA_55AA;
      add(ri, 1'b0, 32'h55AA_55AA, 1'b1, 1'b1, w);
      add(idle, 1'b0, 32'h0, 1'b1, 1'b0, '0);
      // ack while pipeline stalled: data held in WAIT_STALL, stray acks ignored
      rq = mk_req(1'b0, 32'h0000_0030, 4'hF, 32'h0);
      w  = mk_wb(32'h0000_0030, 32'h0, 1'b0, 4'hF);
      add(rq, 1'b1, 32'h0, 1'b1, 1'b0, '0);
      ri = rq; ri.ack = 1'b1; ri.dati = 32'h1234_5678; ri.stall = 6'b000011;
      add(ri, 1'b0, 32'h1234_5678, 1'b1, 1'b1, w);
      ri = rq; ri.stall = 6'b000011;
      add(ri, 1'b0, 32'h1234_5678, 1'b1, 1'b0, '0);
      ri.ack = 1'b1; ri.dati = 32'hFFFF_FFFF;
      add(ri, 1'b0, 32'h1234_5678, 1'b1, 1'b0, '0);
      add(idle, 1'b0, 32'h1234_5678, 1'b1, 1'b0, '0);
      add(idle, 1'b0, 32'h0, 1'b1, 1'b0, '0);
      // ack in IDLE ignored
      ri = idle; ri.ack = 1'b1; ri.dati = 32'hCAFE_F00D;
      add(ri, 1'b0, 32'h0, 1'b1, 1'b0, '0);
      // flush together with ack in BUSY: write dropped, not retried
      rq = mk_req(1'b1, 32'h0000_0040, 4'b0011, 32'h0000_BEEF);
      w  = mk_wb(32'h0000_0040, 32'h0000_BEEF, 1'b1, 4'b0011);
      add(rq, 1'b1, 32'h0, 1'b1, 1'b0, '0);
      ri = rq; ri.flush = 1'b1; ri.ack = 1'b1; ri.dati = 32'h1111_1111;
      add(ri, 1'b0, 32'h0, 1'b1, 1'b1, w);
      add(idle, 1'b0, 32'h0, 1'b1, 1'b0, '0);
      // flush in IDLE blocks a new request
      ri = mk_req(1'b0, 32'h0000_0050, 4'hF, 32'h0); ri.flush = 1'b1;
      add(ri, 1'b0, 32'h0, 1'b1, 1'b0, '0);
      add(idle, 1'b0, 32'h0, 1'b1, 1'b0, '0);
      // write then stall: buffer shows 0; flush in WAIT_STALL returns to IDLE
      rq = mk_req(1'b1, 32'h0000_0060, 4'hF, 32'h9999_9999);
      w  = mk_wb(32'h0000_0060, 32'h9999_9999, 1'b1, 4'hF);
      add(rq, 1'b1, 32'h0, 1'b1, 1'b0, '0);
      ri = rq; ri.ack = 1'b1; ri.dati = 32'h7777_7777; ri.stall = 6'b000001;
      add(ri, 1'b0, 32'h7777_7777, 1'b1, 1'b1, w);
      ri = idle; ri.stall = 6'b000001;
      add(ri, 1'b0, 32'h0, 1'b1, 1'b0, '0);
      ri.flush = 1'b1;
      add(ri, 1'b0, 32'h0, 1'b0, 1'b0, '0);
      ri.flush = 1'b0;
      add(ri, 1'b0, 32'h0, 1'b1, 1'b0, '0);
      // random reads/writes with 0..2 wait states
      for (int t = 0; t < 6; t++) begin
         logic        rwe;
         logic [31:0] radr, rdat, rdi;
         logic [3:0]  rsel;
         int          nw;
         rwe  = 1'($urandom_range(0, 1));
         radr = $urandom() & 32'hFFFF_FFFC;
         rdat = $urandom();
         rdi  = $urandom();
         rsel = 4'($urandom_range(1, 15));
         nw   = $urandom_range(0, 2);
         rq = mk_req(rwe, radr, rsel, rdat);
         w  = mk_wb(radr, rdat, rwe, rsel);
         add(rq, 1'b1, 32'h0, 1'b1, 1'b0, '0);
         for (int k = 0; k < nw; k++) add(rq, 1'b1, 32'h0, 1'b1, 1'b1, w);
         ri = rq; ri.ack = 1'b1; ri.dati = rdi;
         add(ri, 1'b0, rdi, 1'b1, 1'b1, w);
         add(idle, 1'b0, 32'h0, 1'b1, 1'b0, '0);
      end

      // ---- reset ----
      drive(idle);
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      @(posedge clk);
      #2;
      chk("reset stb", 32'(wb_stb_o), 32'h0);
      chk("reset cyc", 32'(wb_cyc_o), 32'h0);
      chk("reset adr", wb_adr_o, 32'h0);
      chk("reset stallreq", 32'(stallreq_o), 32'h0);
      chk("reset cpu_data", cpu_data_o, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // ---- table replay through the scoreboard ----
      for (int k = 0; k < tbl.size(); k++) begin
         @(posedge clk);
         #1 drive(tbl[k].i);
         exp_q.push_back(tbl[k]);
         @(negedge clk);
         v = exp_q.pop_front();
         compare_row(k, v);
      end

      // ---- flush in BUSY clears a previously loaded buffer ----
      cyc(mk_req(1'b0, 32'h0000_0080, 4'hF, 32'h0));
      ri = mk_req(1'b0, 32'h0000_0080, 4'hF, 32'h0);
      ri.ack = 1'b1; ri.dati = 32'hC0FF_EE00; ri.stall = 6'b000100;
      cyc(ri);
      cyc(idle);
      chk("rd_buf loaded", dut.rd_buf, 32'hC0FF_EE00);
      cyc(mk_req(1'b0, 32'h0000_0084, 4'hF, 32'h0));
      ri = mk_req(1'b0, 32'h0000_0084, 4'hF, 32'h0);
      ri.flush = 1'b1; ri.ack = 1'b1; ri.dati = 32'h3C3C_3C3C;
      cyc(ri);
      chk("flush stallreq", 32'(stallreq_o), 32'h0);
      cyc(idle);
      chk("flush rd_buf", dut.rd_buf, 32'h0);
      chk("flush stb", 32'(wb_stb_o), 32'h0);
      chk("flush cyc", 32'(wb_cyc_o), 32'h0);
      chk("flush state", 32'(dut.state), 32'(ST_IDLE));

      // ---- asynchronous reset in the middle of a bus cycle ----
      cyc(mk_req(1'b0, 32'h0000_0070, 4'hF, 32'h0));
      @(posedge clk);
      ri = mk_req(1'b0, 32'h0000_0070, 4'hF, 32'h0);
      ri.ack = 1'b1; ri.dati = 32'hBAD0_BAD0;
      #1 drive(ri);
      chk("pre-reset stb", 32'(wb_stb_o), 32'h1);
      #2 rst_n = 1'b0;
      #1;
      chk("async rst stb", 32'(wb_stb_o), 32'h0);
      chk("async rst cyc", 32'(wb_cyc_o), 32'h0);
      chk("async rst adr", wb_adr_o, 32'h0);
      chk("async rst stallreq", 32'(stallreq_o), 32'h0);
      chk("async rst cpu_data", cpu_data_o, 32'h0);
      drive(idle);
      @(negedge clk);
      rst_n = 1'b1;
      cyc(idle);
      chk("post-rst stb", 32'(wb_stb_o), 32'h0);
      cyc(mk_req(1'b0, 32'h0000_0074, 4'hF, 32'h0));
      chk("post-rst req stallreq", 32'(stallreq_o), 32'h1);
      ri = mk_req(1'b0, 32'h0000_0074, 4'hF, 32'h0);
      ri.ack = 1'b1; ri.dati = 32'hA5A5_0F0F;
      cyc(ri);
      chk("post-rst busy stb", 32'(wb_stb_o), 32'h1);
      chk("post-rst busy adr", wb_adr_o, 32'h0000_0074);
      chk("post-rst ack stallreq", 32'(stallreq_o), 32'h0);
      chk("post-rst ack cpu_data", cpu_data_o, 32'hA5A5_0F0F);
      cyc(idle);
      chk("post-rst done stb", 32'(wb_stb_o), 32'h0);
      chk("post-rst done cyc", 32'(wb_cyc_o), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
